// File: rtl/hazard_controller.sv
// Hazard controller: forwarding selects, load-use and branch stall/flush,
// plus a sequencer that holds E while a long multiply completes.
//
// Ports:
//   clk, reset (async, active-low)
//   Match_* / RegWrite* / MemtoRegE  : register-match and writeback flags
//   PCSrc{D,E,M,W}, BranchTakenE     : control-flow status per stage
//   MulLongE                          : long multiply sitting in E
//   ForwardAE/BE                      : 00 regfile, 01 ResultW, 10 ALUOutM
//   Stall{F,D,E}, Flush{D,E,M}        : pipeline register controls
//   MulBusy                           : multiply sequencer active
// Optional macro HAZARD_PERF_EN adds saturating performance counters
//   PerfStallCnt, PerfFlushCnt, PerfMulCnt (PERF_W bits each).

module hazard_controller #(
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 4,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Match_1E_M,
  input  logic              Match_1E_W,
  input  logic              Match_2E_M,
  input  logic              Match_2E_W,
  input  logic              Match_12D_E,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              PCSrcD,
  input  logic              PCSrcE,
  input  logic              PCSrcM,
  input  logic              PCSrcW,
  input  logic              BranchTakenE,
  input  logic              MulLongE,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] PerfStallCnt,
  output logic [PERF_W-1:0] PerfFlushCnt,
  output logic [PERF_W-1:0] PerfMulCnt,
`endif
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MulBusy
);

  localparam logic [0:0] RUN = 1'b0;
  localparam logic [0:0] MUL = 1'b1;

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(MUL_CYCLES - 1);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ld_stall;
  logic pc_wr_pend;
  logic mul_start;
  logic in_mul;
  logic cnt_zero;

  // ---------------- forwarding ----------------
  // M is newer than W, so it wins when both match.
  always_comb begin
    ForwardAE = FWD_RF;
    if (Match_1E_M && RegWriteM)
      ForwardAE = FWD_M;
    else if (Match_1E_W && RegWriteW)
      ForwardAE = FWD_W;
  end

  always_comb begin
    ForwardBE = FWD_RF;
    if (Match_2E_M && RegWriteM)
      ForwardBE = FWD_M;
    else if (Match_2E_W && RegWriteW)
      ForwardBE = FWD_W;
  end

  // ---------------- hazard terms ----------------
  assign ld_stall   = Match_12D_E & MemtoRegE
                    & RegWriteE;
  assign pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;

  assign in_mul   = (state_q == MUL);
  assign cnt_zero = (cnt_q == '0);

  // A taken branch kills the multiply in E, so
  // the sequencer must not start.
  assign mul_start = ~in_mul & MulLongE
                   & ~BranchTakenE;

  // ---------------- sequencer ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == RUN): begin
        if (mul_start) begin
          state_d = MUL;
          cnt_d   = CNT_INIT;
        end
      end
      (state_q == MUL): begin
        // MulLongE stays high from the held
        // instruction; only the counter matters.
        if (cnt_zero) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------- stall / flush ----------------
  // In MUL the load-use and branch terms are
  // masked; they are seen again back in RUN.
  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    MulBusy = 1'b0;
    unique case (1'b1)
      in_mul: begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallE  = 1'b1;
        FlushM  = 1'b1;
        MulBusy = 1'b1;
      end
      !in_mul: begin
        StallF = ld_stall | pc_wr_pend;
        StallD = ld_stall;
        FlushD = pc_wr_pend | PCSrcW
               | BranchTakenE;
        FlushE = ld_stall | BranchTakenE;
      end
      default: begin
        StallF = 1'b0;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  // ---------------- perf counters ----------------
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [PERF_W-1:0] mul_cnt_q,   mul_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    mul_cnt_d   = mul_cnt_q;
    if (StallF && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if ((FlushD || FlushE) && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (mul_start && !(&mul_cnt_q))
      mul_cnt_d = mul_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      mul_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mul_cnt_q   <= mul_cnt_d;
    end
  end

  assign PerfStallCnt = stall_cnt_q;
  assign PerfFlushCnt = flush_cnt_q;
  assign PerfMulCnt   = mul_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller.
// Expected outputs are queued as stimulus is driven, then popped and checked.

module tb_hazard_controller;

  localparam int PERF_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic Match_1E_M, Match_1E_W;
  logic Match_2E_M, Match_2E_W;
  logic Match_12D_E;
  logic RegWriteE, RegWriteM, RegWriteW;
  logic MemtoRegE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic BranchTakenE, MulLongE;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE;
  logic FlushD, FlushE, FlushM, MulBusy;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] PerfStallCnt;
  logic [PERF_W-1:0] PerfFlushCnt;
  logic [PERF_W-1:0] PerfMulCnt;
`endif

  always #5 clk = ~clk;

  hazard_controller #(
    .MUL_CYCLES(3),
    .CNT_W(4),
    .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Match_1E_M(Match_1E_M),
    .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M),
    .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E),
    .RegWriteE(RegWriteE),
    .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD),
    .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM),
    .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE),
    .MulLongE(MulLongE),
`ifdef HAZARD_PERF_EN
    .PerfStallCnt(PerfStallCnt),
    .PerfFlushCnt(PerfFlushCnt),
    .PerfMulCnt(PerfMulCnt),
`endif
    .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE),
    .StallF(StallF),
    .StallD(StallD),
    .StallE(StallE),
    .FlushD(FlushD),
    .FlushE(FlushE),
    .FlushM(FlushM),
    .MulBusy(MulBusy)
  );

  // Input bit order (MSB first):
  // m1m m1w m2m m2w m12d rwe rwm rww mtr
  // pcd pce pcm pcw bte mul
  typedef logic [14:0] in_t;

  int errors = 0;
  int checks = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [10:0] model(
    input in_t v, input bit mul);
    logic [1:0] fa, fb;
    logic ld, pend;
    logic sf, sd, se, fd, fe, fm, mb;
    fa = v[14] & v[8] ? 2'b10 :
         v[13] & v[7] ? 2'b01 : 2'b00;
    fb = v[12] & v[8] ? 2'b10 :
         v[11] & v[7] ? 2'b01 : 2'b00;
    ld   = v[10] & v[9] & v[6];
    pend = v[5] | v[4] | v[3];
    if (mul) begin
      sf = 1; sd = 1; se = 1;
      fd = 0; fe = 0; fm = 1; mb = 1;
    end else begin
      sf = ld | pend;
      sd = ld;
      se = 0;
      fd = pend | v[2] | v[1];
      fe = ld | v[1];
      fm = 0; mb = 0;
    end
    return {fa, fb, sf, sd, se, fd, fe, fm, mb};
  endfunction

  function automatic logic [10:0] obs();
    return {ForwardAE, ForwardBE, StallF,
            StallD, StallE, FlushD, FlushE,
            FlushM, MulBusy};
  endfunction

  task automatic apply(input in_t v);
    {Match_1E_M, Match_1E_W, Match_2E_M,
     Match_2E_W, Match_12D_E, RegWriteE,
     RegWriteM, RegWriteW, MemtoRegE,
     PCSrcD, PCSrcE, PCSrcM, PCSrcW,
     BranchTakenE, MulLongE} = v;
  endtask

  task automatic check_head();
    logic [10:0] e, o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = obs();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b",
             t, o, e);
    end
  endtask

  // Drive after the falling edge, check 1 time
  // unit later, well before the next rising edge.
  task automatic step(input string t,
                      input in_t v,
                      input bit mul);
    @(negedge clk);
    apply(v);
    exp_q.push_back(model(v, mul));
    tag_q.push_back(t);
    #1;
    check_head();
  endtask

  localparam in_t Z   = 15'b0;
  localparam in_t LDU = 15'b000011001000000;
  localparam in_t MULL = 15'b000000000000001;

  initial begin
    reset = 1'b0;
    apply(Z);
    #2;
    exp_q.push_back(model(Z, 0));
    tag_q.push_back("reset_state");
    check_head();
`ifdef HAZARD_PERF_EN
    checks++;
    assert ({PerfStallCnt, PerfFlushCnt,
             PerfMulCnt} === '0) else begin
      errors++;
      $error("FAIL perf_reset observed=%h %h %h expected=0",
             PerfStallCnt, PerfFlushCnt, PerfMulCnt);
    end
`endif
    @(negedge clk);
    reset = 1'b1;

    // forwarding priority on A and B
    step("fwdA_M",   15'b110000110000000, 0);
    step("fwdA_W",   15'b110000010000000, 0);
    step("fwdA_RF",  15'b110000000000000, 0);
    step("fwdB_M",   15'b001100110000000, 0);
    step("fwdB_W",   15'b000100010000000, 0);

    // load-use for a single cycle
    step("lduse",    LDU, 0);
    step("lduse_off", Z, 0);

    // long multiply: entry cycle then 3 holds,
    // load-use presented throughout is masked
    step("mul_entry", MULL, 0);
    step("mul_hold1", MULL | LDU, 1);
    step("mul_hold2", MULL | LDU, 1);
    step("mul_hold3", MULL | LDU, 1);
    step("mul_exit_ld", LDU, 0);
    step("mul_idle", Z, 0);

    // PC-writing instruction walking D,E,M,W
    step("pcsrcD", 15'b000000000100000, 0);
    step("pcsrcE", 15'b000000000010000, 0);
    step("pcsrcM", 15'b000000000001000, 0);
    step("pcsrcW", 15'b000000000000100, 0);
    step("pc_idle", Z, 0);

    // branch beats multiply
    step("br_mul", 15'b000000000000011, 0);
    step("br_mul_after", Z, 0);
    // load-use together with taken branch
    step("br_ld", LDU | 15'b10, 0);

    // reset during second MUL cycle
    step("rmul_entry", MULL, 0);
    step("rmul_hold1", MULL, 1);
    step("rmul_hold2", MULL, 1);
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(model(MULL, 0));
    tag_q.push_back("async_reset_mid_mul");
    check_head();
`ifdef HAZARD_PERF_EN
    checks++;
    assert ({PerfStallCnt, PerfFlushCnt,
             PerfMulCnt} === '0) else begin
      errors++;
      $error("FAIL perf_cleared observed=%h %h %h expected=0",
             PerfStallCnt, PerfFlushCnt, PerfMulCnt);
    end
`endif
    @(negedge clk);
    apply(Z);
    reset = 1'b1;
    step("post_reset_run", Z, 0);
    // fresh entry still gives exactly 3 holds
    step("re_entry", MULL, 0);
    step("re_hold1", MULL, 1);
    step("re_hold2", MULL, 1);
    step("re_hold3", Z, 1);
    step("re_done", Z, 0);
`ifdef HAZARD_PERF_EN
    checks++;
    assert (PerfMulCnt === PERF_W'(1)) else begin
      errors++;
      $error("FAIL perf_mul observed=%0d expected=1",
             PerfMulCnt);
    end
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline hazard and sequencing controller for the 5-stage F/D/E/M/W datapath.
- Consumes the datapath's register-match flags and the stage control bits.
- Drives forwarding selects, stalls and flushes.
- Contains a multi-cycle sequencer that holds the E stage while a long (64-bit) multiply completes.
- Sits beside the controller; all outputs go directly to the datapath pipeline registers and bypass muxes.

Parameters:
MUL_CYCLES, 3, extra E-stage cycles a long multiply occupies (legal range 1..15).
CNT_W, 4, width of the multiply cycle counter.
PERF_W, 16, width of each performance counter (optional feature only).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
Match_1E_M  in  1  E-stage source 1 matches the M-stage destination.
Match_1E_W  in  1  E-stage source 1 matches the W-stage destination.
Match_2E_M  in  1  E-stage source 2 matches the M-stage destination.
Match_2E_W  in  1  E-stage source 2 matches the W-stage destination.
Match_12D_E  in  1  a D-stage source matches the E-stage destination.
RegWriteE  in  1  E instruction writes a register.
RegWriteM  in  1  M instruction writes a register.
RegWriteW  in  1  W instruction writes a register.
MemtoRegE  in  1  E instruction is a load.
PCSrcD  in  1  PC-writing instruction in D.
PCSrcE  in  1  PC-writing instruction in E.
PCSrcM  in  1  PC-writing instruction in M.
PCSrcW  in  1  PC-writing instruction in W.
BranchTakenE  in  1  branch resolved taken in E.
MulLongE  in  1  E instruction is a long multiply.
ForwardAE  out  2  source A bypass select: 00 register file, 01 ResultW, 10 ALUOutM.
ForwardBE  out  2  source B bypass select; same encoding as ForwardAE.
StallF  out  1  hold the PC register.
StallD  out  1  hold the D-stage register.
StallE  out  1  hold the E-stage registers.
FlushD  out  1  clear the D-stage register.
FlushE  out  1  clear the E-stage registers.
FlushM  out  1  inject a bubble into the E->M registers.
MulBusy  out  1  multiply sequencer is active.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, counter=0, MulBusy=0, StallE=0, FlushM=0.
  - Combinational outputs follow their inputs immediately.
- Forwarding (combinational):
  - ForwardAE = 10 if Match_1E_M & RegWriteM; else 01 if Match_1E_W & RegWriteW; else 00.
  - ForwardBE uses the same rule with the Match_2E_* flags.
  - M has priority over W.
- Load-use: LdStall = Match_12D_E & MemtoRegE & RegWriteE.
- Branch pending: PCWrPend = PCSrcD | PCSrcE | PCSrcM.
- State machine:
  - RUN -> MUL when MulLongE & ~BranchTakenE; the counter loads MUL_CYCLES-1.
  - MUL: the counter decrements each cycle. At counter=0, return to RUN on the next edge.
  - Total hold = MUL_CYCLES cycles, starting the cycle after entry.
  - MulLongE is ignored while in MUL (the held instruction keeps asserting it).
- Outputs in MUL:
  - StallF=StallD=StallE=1, FlushM=1, MulBusy=1.
  - FlushD=0, FlushE=0.
  - LdStall and PCWrPend are masked; they are re-evaluated on return to RUN.
- Outputs in RUN:
  - StallF = LdStall | PCWrPend.
  - StallD = LdStall.
  - FlushD = PCWrPend | PCSrcW | BranchTakenE.
  - FlushE = LdStall | BranchTakenE.
  - StallE=0, FlushM=0.
- Simultaneous events:
  - BranchTakenE with MulLongE: the branch wins and MUL is not entered. Decode makes these mutually exclusive.
  - LdStall with BranchTakenE: both apply (FlushE=1, FlushD=1, StallF=1). The flushed load-use pair re-fetches.
- Reset asserted mid-MUL: immediate return to RUN, stalls deassert asynchronously, counter cleared.

Optional Feature:
Macro: HAZARD_PERF_EN
- With the macro defined, add these outputs:
  - PerfStallCnt (PERF_W): counts cycles with StallF=1.
  - PerfFlushCnt (PERF_W): counts cycles with FlushD=1 or FlushE=1.
  - PerfMulCnt (PERF_W): counts MUL entries.
- All counters are saturating (hold at all-ones) and cleared by reset.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
1. Match_1E_M=1, RegWriteM=1, Match_1E_W=1, RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> ForwardAE=01. Then both RegWrite=0 -> ForwardAE=00.
2. Match_12D_E=1, MemtoRegE=1, RegWriteE=1 for one cycle -> StallF=1, StallD=1, FlushE=1 that cycle only; StallE=0.
3. MulLongE=1 held, MUL_CYCLES=3 -> MulBusy/StallE/StallF/StallD/FlushM=1 for exactly 3 cycles after entry, then 0. Concurrent LdStall is masked during those cycles.
4. PCSrcD, PCSrcE, PCSrcM, PCSrcW pulsed in successive cycles -> StallF=1 for 3 cycles. FlushD=1 for 4 cycles.
5. BranchTakenE=1 with MulLongE=1 -> FlushD=1, FlushE=1, MulBusy stays 0.
6. reset low during the 2nd MUL cycle -> StallE and MulBusy drop without a clock edge. After release, RUN with counter=0. With HAZARD_PERF_EN, all counters read 0.
